// File: rtl/omux_pkg.sv
// Shared constants and types for the output-mux arbiter and its byte FIFO.
package omux_pkg;
  localparam int OMUX_W = 8;
  typedef enum logic {IDLE, GRANT} arb_state_e;
endpackage

// File: rtl/omux_fifo.sv
// Synchronous byte FIFO between the requester mux and the FT2232 write port.
module omux_fifo
  import omux_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     push_i,
  input  logic [OMUX_W-1:0]        din_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [OMUX_W-1:0]        dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [OMUX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/omux_arbiter.sv
// Packet-granular round-robin arbiter of N byte requesters onto the FT2232 TX path.
module omux_arbiter
  import omux_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [OMUX_W*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]        sel_o,
  input  logic                    ft_txe_ni,
  output logic                    ft_wr_o,
  output logic [OMUX_W-1:0]       ft_data_o
);
  localparam int RRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;

  arb_state_e        state_q;
  logic [RRW-1:0]    g_q, rr_q, g_d, idx;
  logic              g_req, full, empty;
  logic [CW-1:0]     count;
  logic [OMUX_W-1:0] din;

  // First requester with req high, searching from rr upward with wrap.
  always_comb begin
    g_d = rr_q;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (int'(rr_q) + i >= N_REQ) idx = RRW'(int'(rr_q) + i - N_REQ);
      else                         idx = RRW'(int'(rr_q) + i);
      if (req_i[idx]) g_d = idx;
    end
  end

  // Full gates sel so txe never reaches sel combinationally.
  always_comb begin
    sel_o = '0;
    g_req = 1'b0;
    din   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (g_q == RRW'(k)) begin
        g_req    = req_i[k];
        din      = data_i[k*OMUX_W +: OMUX_W];
        sel_o[k] = (state_q == GRANT) && req_i[k] && !full;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_i) begin
          g_q     <= g_d;
          state_q <= GRANT;
        end
        GRANT: if (!g_req) begin
          rr_q    <= (int'(g_q) == N_REQ - 1) ? '0 : g_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ft_wr_o = !empty && !ft_txe_ni;

  omux_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (|sel_o),
    .din_i    (din),
    .full_o   (full),
    .pop_i    (ft_wr_o),
    .dout_o   (ft_data_o),
    .empty_o  (empty),
    .count_o  (count)
  );

  logic unused_count;
  assign unused_count = ^count;
endmodule
